mem_req_bridge: RTL and testbench

MEM_REQ_BRIDGE -- requirements
Module: mem_req_bridge

---
 rtl/mem_pkg.sv | 23 ++
 rtl/req_fifo.sv | 65 ++++++
 rtl/mem_req_bridge.sv | 175 +++++++++++++++++
 tb/tb_mem_req_bridge.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Purpose : shared types for the memory request bridge (widths, request record, engine states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

   localparam int MEM_AW = 4;
   localparam int MEM_DW = 32;

   // One buffered request as it sits in the request FIFO.
   typedef struct packed {
      logic              we;
      logic [MEM_AW-1:0] addr;
      logic [MEM_DW-1:0] wdata;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/req_fifo.sv
// Purpose : request buffer, DEPTH entries (power of 2, >= 2) of WIDTH bits, head visible without a pop.
// Latency : a push is visible at the head the cycle after it is written.
// Backpressure: 'ready' is registered and drops once the buffer holds DEPTH entries; pushes while full are dropped.
// Ports   : clk, rst (sync, active high); push/push_data in; pop in, head out; ready, full, empty out.
module req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             ready,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ready is the registered form of (count < DEPTH); it reads 0 while in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ready   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_d;
         ready   <= (count_d < CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_req_bridge.sv
// Purpose : buffers read/write requests and drives a single-port memory, one read outstanding, read timeout.
// Latency : idle accept at edge k -> mem_en k+1..k+2; read data at edge k+3 -> rsp_valid from k+3.
// Backpressure: req_ready low while the request FIFO is full; a held response blocks further issue.
// Ports   : clk, rst (sync, active high); req_* request in; rsp_* response out;
//           mem_* memory strobe/address/data out, mem_data_out/mem_valid_out in; spurious_cnt out.
module mem_req_bridge #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 8,
   parameter int MEM_AW     = mem_pkg::MEM_AW,
   parameter int MEM_DW     = mem_pkg::MEM_DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [MEM_AW-1:0] req_addr,
   input  logic [MEM_DW-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [MEM_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_re,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [MEM_DW-1:0] mem_data_in,
   input  logic [MEM_DW-1:0] mem_data_out,
   input  logic              mem_valid_out,
   output logic [7:0]        spurious_cnt
);

   import mem_pkg::*;

   localparam int RW = 1 + MEM_AW + MEM_DW;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state_q;
   state_t            state_d;
   logic [TW-1:0]     tmo_q;
   logic [TW-1:0]     tmo_d;

   logic              mem_en_d;
   logic              mem_re_d;
   logic [MEM_AW-1:0] mem_addr_d;
   logic [MEM_DW-1:0] mem_data_in_d;
   logic              rsp_valid_d;
   logic [MEM_DW-1:0] rsp_rdata_d;
   logic              rsp_err_d;

   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [RW-1:0]     head;
   logic              head_we;
   logic [MEM_AW-1:0] head_addr;
   logic [MEM_DW-1:0] head_wdata;

   assign {head_we, head_addr, head_wdata} = head;

   // full is redundant with the registered ready, but keeps a push off a full buffer by construction.
   assign push = req_valid & req_ready & ~full;

   req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RW)
   ) u_req_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({req_we, req_addr, req_wdata}),
      .pop       (pop),
      .head      (head),
      .ready     (req_ready),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      pop           = 1'b0;
      mem_en_d      = 1'b0;
      mem_re_d      = mem_re;
      mem_addr_d    = mem_addr;
      mem_data_in_d = mem_data_in;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;

      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         // mem_re here describes the access strobed this cycle.
         ISSUE: begin
            if (mem_re) begin
               state_d = WAIT;
               tmo_d   = '0;
            end else if (!empty) begin
               pop = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         // tmo_q counts completed empty WAIT cycles; the TIMEOUT-th one ends the wait with an error.
         WAIT: begin
            if (mem_valid_out) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = mem_data_out;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         mem_en_d      = 1'b1;
         mem_re_d      = ~head_we;
         mem_addr_d    = head_addr;
         mem_data_in_d = head_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tmo_q       <= '0;
         mem_en      <= 1'b0;
         mem_re      <= 1'b0;
         mem_addr    <= '0;
         mem_data_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         mem_en      <= mem_en_d;
         mem_re      <= mem_re_d;
         mem_addr    <= mem_addr_d;
         mem_data_in <= mem_data_in_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
      end
   end

   // Read data arriving when no read is waiting is discarded and only counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         spurious_cnt <= '0;
      end else if (mem_valid_out && (state_q != WAIT) && (spurious_cnt != 8'hFF)) begin
         spurious_cnt <= spurious_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Purpose : self-checking bench for mem_req_bridge: request-order model, response model, directed scenarios.
// Latency : n/a.
// Backpressure: exercised with held and randomised rsp_ready and a filled request buffer.
module tb_mem_req_bridge;
   import mem_pkg::*;

   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   wire           rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          mem_en;
   logic          mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;
   logic          mem_valid_out;
   logic [7:0]    spurious_cnt;

   logic rdy_dir = 1'b1;
   logic rdy_rnd = 1'b1;
   logic rand_rdy = 1'b0;
   assign rsp_ready = rand_rdy ? rdy_rnd : rdy_dir;

   always #5 clk = ~clk;

   mem_req_bridge dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .mem_en        (mem_en),
      .mem_re        (mem_re),
      .mem_addr      (mem_addr),
      .mem_data_in   (mem_data_in),
      .mem_data_out  (mem_data_out),
      .mem_valid_out (mem_valid_out),
      .spurious_cnt  (spurious_cnt)
   );

   // ---------------- memory responder (cleared on rst) ----------------
   logic [DW-1:0] phys [16];
   logic          rd_vld_q = 1'b0;
   logic [DW-1:0] rd_dat_q = '0;
   logic          drop_mode = 1'b0;
   logic          spur = 1'b0;

   always @(posedge clk) begin
      rd_vld_q <= 1'b0;
      if (rst) begin
         for (int i = 0; i < 16; i++) phys[i] <= '0;
      end else if (mem_en) begin
         if (!mem_re) phys[mem_addr] <= mem_data_in;
         else if (!drop_mode) begin
            rd_vld_q <= 1'b1;
            rd_dat_q <= phys[mem_addr];
         end
      end
   end
   assign mem_valid_out = rd_vld_q | spur;
   assign mem_data_out  = rd_dat_q;

   always @(negedge clk) if (rand_rdy) rdy_rnd = 1'($urandom_range(0, 1));

   // ---------------- reference model ----------------
   mem_req_t      exp_issue [$];
   logic [DW:0]   exp_rsp [$];      // {err, rdata}
   logic [DW-1:0] model_mem [16];
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // ---------------- compare process ----------------
   logic        held = 1'b0;
   logic [DW:0] held_val = '0;
   logic [DW:0] last_rsp_val = '0;
   int          last_rsp_cyc = -1;
   int          outstanding = 0;
   int          iss_cyc [$];
   logic [AW-1:0] iss_addr [$];
   logic        iss_re [$];

   always begin
      logic     hs;
      mem_req_t e;
      @(posedge clk);
      hs = rsp_valid & rsp_ready;
      #1;
      if (rst) begin
         held = 1'b0;
         outstanding = 0;
      end else begin
         if (hs) begin
            if (exp_rsp.size() > 0) void'(exp_rsp.pop_front());
            held = 1'b0;
            outstanding--;
         end
         if (mem_en) begin
            iss_cyc.push_back(cyc);
            iss_addr.push_back(mem_addr);
            iss_re.push_back(mem_re);
            if (exp_issue.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_issue: mem_en with addr 0x%0h, required no access (cycle %0d)", mem_addr, cyc);
            end else begin
               e = exp_issue.pop_front();
               chk("issue_re", 64'(mem_re), 64'(!e.we));
               chk("issue_addr", 64'(mem_addr), 64'(e.addr));
               if (e.we) chk("issue_wdata", 64'(mem_data_in), 64'(e.wdata));
               else begin
                  chk("one_read_outstanding", 64'(outstanding), 64'(0));
                  outstanding++;
               end
            end
         end
         if (rsp_valid) begin
            if (!held) begin
               held = 1'b1;
               held_val = {rsp_err, rsp_rdata};
               last_rsp_val = {rsp_err, rsp_rdata};
               last_rsp_cyc = cyc;
               if (exp_rsp.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_rsp: rsp_valid with data 0x%0h, required none (cycle %0d)", rsp_rdata, cyc);
               end else begin
                  chk("rsp_value", 64'({rsp_err, rsp_rdata}), 64'(exp_rsp[0]));
               end
            end else begin
               chk("rsp_stable", 64'({rsp_err, rsp_rdata}), 64'(held_val));
            end
         end
      end
   end

   // ---------------- stimulus helpers (enter and leave at a negedge) ----------------
   task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int acc_cyc, output logic first_rdy);
      int       w;
      mem_req_t r;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      first_rdy = req_ready;
      w = 0;
      while (!req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", w);
         req_valid = 1'b0;
         acc_cyc = -1;
      end else begin
         r.we = we;
         r.addr = addr;
         r.wdata = data;
         exp_issue.push_back(r);
         if (we) model_mem[addr] = data;
         else exp_rsp.push_back(drop_mode ? {1'b1, {DW{1'b0}}} : {1'b0, model_mem[addr]});
         @(negedge clk);
         acc_cyc = cyc;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || rsp_valid) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: %0d issues, %0d responses pending, required none", exp_issue.size(), exp_rsp.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_model();
      exp_issue.delete();
      exp_rsp.delete();
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
      chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
      chk({tag, "_mem_re"}, 64'(mem_re), 64'(0));
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
      chk({tag, "_mem_data_in"}, 64'(mem_data_in), 64'(0));
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
      chk({tag, "_spurious"}, 64'(spurious_cnt), 64'(0));
   endtask

   task automatic clear_log();
      iss_cyc.delete();
      iss_addr.delete();
      iss_re.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int   k;
      int   k0;
      logic r;
      logic ok_all;
      int   seen;

      clear_model();
      repeat (3) @(negedge clk);
      chk_reset("rst");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 64'(req_ready), 64'(1));

      // write then read back on an idle bridge
      clear_log();
      send(1'b1, 4'd3, 32'hDEADBEEF, k, r);
      wait_idle();
      send(1'b0, 4'd3, 32'h0, k, r);
      wait_idle();
      chk("wr_rd_issues", 64'(iss_re.size()), 64'(2));
      chk("wr_rd_first_re", 64'(iss_re[0]), 64'(0));
      chk("wr_rd_second_re", 64'(iss_re[1]), 64'(1));
      chk("rd_issue_cycle", 64'(iss_cyc[1]), 64'(k + 1));
      chk("rd_rsp_cycle", 64'(last_rsp_cyc), 64'(k + 3));
      chk("rd_rsp_value", 64'(last_rsp_val), 64'({1'b0, 32'hDEADBEEF}));

      // four back-to-back writes
      clear_log();
      ok_all = 1'b1;
      k0 = 0;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 4'(i), 32'h1000 + 32'(i), k, r);
         if (i == 0) k0 = k;
         ok_all = ok_all & r;
      end
      wait_idle();
      chk("b2b_ready_held", 64'(ok_all), 64'(1));
      chk("b2b_issue_count", 64'(iss_cyc.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("b2b_issue_cycle", 64'(iss_cyc[i]), 64'(k0 + 1 + i));
         chk("b2b_issue_addr", 64'(iss_addr[i]), 64'(i));
      end

      // held response fills the buffer
      clear_log();
      rdy_dir = 1'b0;
      send(1'b0, 4'd2, 32'h0, k, r);
      for (int i = 0; i < 4; i++) send(1'b1, 4'(4 + i), 32'h2000 + 32'(i), k, r);
      fork
         send(1'b1, 4'd8, 32'h2004, k, r);
         begin
            for (int i = 0; i < 4; i++) begin
               chk("full_ready_low", 64'(req_ready), 64'(0));
               chk("held_rdata", 64'(rsp_rdata), 64'(32'h1002));
               chk("held_valid", 64'(rsp_valid), 64'(1));
               @(negedge clk);
            end
            rdy_dir = 1'b1;
         end
      join
      chk("fifth_offer_not_ready", 64'(r), 64'(0));
      wait_idle();
      chk("full_issue_count", 64'(iss_addr.size()), 64'(6));
      for (int i = 1; i < 6; i++) chk("full_issue_order", 64'(iss_addr[i]), 64'(3 + i));

      // read timeout, then a normal read
      drop_mode = 1'b1;
      send(1'b0, 4'd5, 32'h0, k, r);
      wait_idle();
      chk("tmo_rsp_cycle", 64'(last_rsp_cyc), 64'(k + 10));
      chk("tmo_rsp_value", 64'(last_rsp_val), 64'({1'b1, 32'h0}));
      drop_mode = 1'b0;
      send(1'b0, 4'd0, 32'h0, k, r);
      wait_idle();
      chk("post_tmo_cycle", 64'(last_rsp_cyc), 64'(k + 3));
      chk("post_tmo_value", 64'(last_rsp_val), 64'({1'b0, 32'h1000}));

      // spurious pulses in IDLE, then reset while waiting for read data
      for (int i = 0; i < 3; i++) begin
         spur = 1'b1;
         @(negedge clk);
         spur = 1'b0;
         @(negedge clk);
      end
      chk("spurious_three", 64'(spurious_cnt), 64'(3));
      drop_mode = 1'b1;
      send(1'b0, 4'd1, 32'h0, k, r);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_model();
      @(negedge clk);
      chk_reset("midrst");
      rst = 1'b0;
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      chk("late_spurious", 64'(spurious_cnt), 64'(1));
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("no_rsp_after_rst", 64'(seen), 64'(0));
      drop_mode = 1'b0;

      // randomised traffic against the model
      rand_rdy = 1'b1;
      for (int n = 0; n < 200; n++) begin
         send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, k, r);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      drop_mode = 1'b1;
      for (int n = 0; n < 8; n++) send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, k, r);
      wait_idle();
      drop_mode = 1'b0;
      rand_rdy = 1'b0;
      for (int n = 0; n < 20; n++) send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, k, r);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      tests++;
      fails++;
      $display("FAIL watchdog: run still active at time %0t, required completion", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
